instr_fetcher: RTL and testbench
================================

// Module: instr_fetcher
// PURPOSE
//  Front-end fetch stage directly upstream of mem_ctrl: holds the PC and looks it up in a direct-mapped
//  instruction cache. Misses go to mem_ctrl's instruction-fetcher port (one 32-bit word per request).
//  Delivers {instr, pc} to the instr queue one per cycle on hits. Redirects on clear_flag_in (mispredict/flush).
// PARAMETERS
//  RESET_PC      32'h0  PC loaded on reset
//  ICACHE_LINES  64     cache entries, 1 word each, power of 2; IDX=log2(ICACHE_LINES)
// PORTS
//  clk                 in   1   clock, all state on posedge
//  rst                 in   1   reset, asynchronous, active-low (0 = reset)
//  rdy                 in   1   global ready; 0 freezes block
//  clear_flag_in       in   1   flush/redirect request
//  clear_pc_in         in   32  redirect target
//  mc_fetch_enable_out out  1   one-cycle request pulse to mem_ctrl
//  mc_addr_out         out  32  fetch address, held stable until result
//  mc_result_enable_in in   1   mem_ctrl result valid
//  mc_data_in          in   32  fetched word (little-endian assembled)
//  iq_full_in          in   1   instr queue cannot accept this cycle
//  iq_enable_out       out  1   instr valid to queue (one-cycle pulse)
//  iq_instr_out        out  32  instruction word
//  iq_pc_out           out  32  PC of that instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, all valid bits 0, mc_fetch_enable_out=0, mc_addr_out=32'hFFFFFFFF,
//   iq_enable_out=0, iq_instr_out=0, iq_pc_out=0.
//  Index = pc[IDX+1:2], tag = pc[31:IDX+2]; pc[1:0] always 00 (clear_pc_in[1:0] forced 00).
//  Freeze: rdy=0 -> no state/cache/pc change; mc_fetch_enable_out and iq_enable_out forced 0.
//  Pulses: mc_fetch_enable_out, iq_enable_out default 0 every cycle unless set below.
//  FETCH:
//   - hit & !iq_full_in: iq_enable_out=1, iq_instr_out=cache[idx], iq_pc_out=pc, pc+=4. Stay FETCH.
//     Latency: 1 cycle, 1 instr/cycle sustained.
//   - hit & iq_full_in: nothing; stay.
//   - miss & mc_result_enable_in=0: mc_fetch_enable_out=1, mc_addr_out=pc -> WAIT.
//     Never request while mc_result_enable_in=1 (avoids taking a stale pulse).
//  WAIT:
//   - mc_addr_out held.
//   - on mc_result_enable_in: cache[idx]<=mc_data_in, tag written, valid=1. Word also latched in buf.
//   - if !iq_full_in same cycle: emit {buf,pc}, pc+=4 -> FETCH.
//   - else -> HOLD.
//  HOLD: when !iq_full_in: emit {buf,pc}, pc+=4 -> FETCH. Exactly one emit per fill.
//  Clear (highest priority, any state):
//   - pc<=clear_pc_in -> FETCH; iq_enable_out=0, mc_fetch_enable_out=0, mc_addr_out=32'hFFFFFFFF.
//   - result arriving same cycle as clear or after it is discarded and not written to cache
//     (mem_ctrl drops its transfer on the same flag).
//   - cache contents kept.
//  Wrap: pc+4 wraps modulo 2^32. Conflict (same index, different tag) = miss, line overwritten.
//  Reset mid-WAIT: all state returns to reset values immediately; any later result ignored.
// CONFIGURATION
//  ICACHE_EN defined: cache as above.
//  ICACHE_EN undefined: no tag/data/valid storage; every FETCH is a miss (WAIT/HOLD path only).
//   Same port timing; throughput one instr per mem_ctrl round-trip.
// TESTING
//  1. rst low then high, RESET_PC=0 -> next enabled cycle mc_fetch_enable_out=1 for 1 cycle,
//     mc_addr_out=0x0, iq_enable_out=0.
//  2. In WAIT, drive mc_result_enable_in=1, mc_data_in=0x00500093 -> next cycle iq_enable_out=1,
//     iq_instr_out=0x00500093, iq_pc_out=0x0; then request at 0x4.
//  3. Fill 0x0..0xC, clear_pc_in=0x0 -> 4 consecutive iq_enable_out pulses, pc 0x0,0x4,0x8,0xC,
//     no mc_fetch_enable_out (ICACHE_EN).
//  4. iq_full_in=1 when result arrives -> iq_enable_out stays 0; drop iq_full_in 3 cycles later ->
//     exactly one emit, correct pc.
//  5. clear_flag_in=1 with clear_pc_in=0x100 in same cycle as mc_result_enable_in -> no emit,
//     no cache write, next request mc_addr_out=0x100.
//  6. ICACHE_LINES=64: fetch 0x0 then 0x100 (same index) then 0x0 -> three misses.
//     ICACHE_EN off: repeat test 3 -> 4 mc requests.

Source files
------------

// File: rtl/instr_fetcher.sv
// instr_fetcher: holds the PC, looks it up in a direct-mapped I-cache and feeds {instr, pc} to the instr queue.
// Define ICACHE_EN to build the cache; without it every fetch is served by a mem_ctrl round-trip.
module instr_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  input  logic [31:0] clear_pc_in,
  output logic        mc_fetch_enable_out,
  output logic [31:0] mc_addr_out,
  input  logic        mc_result_enable_in,
  input  logic [31:0] mc_data_in,
  input  logic        iq_full_in,
  output logic        iq_enable_out,
  output logic [31:0] iq_instr_out,
  output logic [31:0] iq_pc_out
);

  // state | meaning
  // FETCH | look up pc: emit on hit, request mem_ctrl on miss
  // WAIT  | request outstanding, mc_addr_out held until the result
  // HOLD  | word returned while the queue was full; emit once it frees
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fill_buf;
  logic [31:0] hit_instr;
  logic        hit;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("instr_fetcher: ICACHE_LINES must be a power of two >= 2");
  end

`ifdef ICACHE_EN
  localparam int IDX = $clog2(ICACHE_LINES);
  localparam int TW  = 30 - IDX;

  logic [IDX-1:0]          idx;
  logic [TW-1:0]           tag;
  logic [ICACHE_LINES-1:0] valid_q;
  logic [31:0]             data_mem [ICACHE_LINES];
  logic [TW-1:0]           tag_mem  [ICACHE_LINES];
  logic                    fill;

  assign idx       = pc[IDX+1:2];
  assign tag       = pc[31:IDX+2];
  assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
  assign hit_instr = data_mem[idx];
  // a result coinciding with a clear belongs to a dropped transfer and must not land in the cache
  assign fill      = rdy && !clear_flag_in && (state == WAIT) && mc_result_enable_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[idx] <= mc_data_in;
      tag_mem[idx]  <= tag;
    end
  end
`else
  assign hit       = 1'b0;
  assign hit_instr = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= FETCH;
      pc                  <= RESET_PC;
      fill_buf            <= 32'h0;
      mc_fetch_enable_out <= 1'b0;
      mc_addr_out         <= 32'hFFFF_FFFF;
      iq_enable_out       <= 1'b0;
      iq_instr_out        <= 32'h0;
      iq_pc_out           <= 32'h0;
    end else begin
      mc_fetch_enable_out <= 1'b0;
      iq_enable_out       <= 1'b0;
      if (rdy) begin
        if (clear_flag_in) begin
          pc          <= clear_pc_in & 32'hFFFF_FFFC;
          state       <= FETCH;
          mc_addr_out <= 32'hFFFF_FFFF;
        end else begin
          case (state)
            FETCH: begin
              if (hit) begin
                if (!iq_full_in) begin
                  iq_enable_out <= 1'b1;
                  iq_instr_out  <= hit_instr;
                  iq_pc_out     <= pc;
                  pc            <= pc + 32'd4;
                end
              end else if (!mc_result_enable_in) begin
                // a result pulse visible now could only be stale, so wait it out
                mc_fetch_enable_out <= 1'b1;
                mc_addr_out         <= pc;
                state               <= WAIT;
              end
            end
            WAIT: begin
              if (mc_result_enable_in) begin
                fill_buf <= mc_data_in;
                if (!iq_full_in) begin
                  iq_enable_out <= 1'b1;
                  iq_instr_out  <= mc_data_in;
                  iq_pc_out     <= pc;
                  pc            <= pc + 32'd4;
                  state         <= FETCH;
                end else begin
                  state <= HOLD;
                end
              end
            end
            HOLD: begin
              if (!iq_full_in) begin
                iq_enable_out <= 1'b1;
                iq_instr_out  <= fill_buf;
                iq_pc_out     <= pc;
                pc            <= pc + 32'd4;
                state         <= FETCH;
              end
            end
            default: state <= FETCH;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Bench for instr_fetcher: acts as mem_ctrl and instr queue, checks against a program-order/cache-content model.
module tb_instr_fetcher;
  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear_flag_in;
  logic [31:0] clear_pc_in;
  logic        mc_fetch_enable_out;
  logic [31:0] mc_addr_out;
  logic        mc_result_enable_in;
  logic [31:0] mc_data_in;
  logic        iq_full_in;
  logic        iq_enable_out;
  logic [31:0] iq_instr_out;
  logic [31:0] iq_pc_out;

  always #5 clk = ~clk;

  instr_fetcher #(.RESET_PC(32'h0), .ICACHE_LINES(LINES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .clear_flag_in(clear_flag_in), .clear_pc_in(clear_pc_in),
    .mc_fetch_enable_out(mc_fetch_enable_out), .mc_addr_out(mc_addr_out),
    .mc_result_enable_in(mc_result_enable_in), .mc_data_in(mc_data_in),
    .iq_full_in(iq_full_in), .iq_enable_out(iq_enable_out),
    .iq_instr_out(iq_instr_out), .iq_pc_out(iq_pc_out)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // model: next expected pc in program order, which address each cache line holds, one outstanding request
  logic [31:0] exp_pc;
  logic [31:0] req_addr;
  logic [31:0] cache_model [int];
  bit          pending;
  bit          fill_ready;
  bit          rand_lat;
  int          lat;
  int          req_count;
  int          emit_count;
  int          fill_count;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int line_of(logic [31:0] a);
    return int'((a >> 2) & (LINES - 1));
  endfunction

  function automatic bit model_hit(logic [31:0] a);
`ifdef ICACHE_EN
    int l = line_of(a);
    return cache_model.exists(l) && (cache_model[l] == a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit a_rdy, a_clr, a_res, a_full;
    logic [31:0] a_cpc;
    a_rdy = rdy; a_clr = clear_flag_in; a_res = mc_result_enable_in; a_full = iq_full_in;
    a_cpc = clear_pc_in;
    @(posedge clk); #1;
    if (a_rdy && a_clr) begin
      exp_pc = a_cpc & 32'hFFFF_FFFC;
      pending = 0;
      fill_ready = 0;
      chk("clear_addr", mc_addr_out, 32'hFFFF_FFFF);
      chk("clear_no_emit", iq_enable_out, 0);
    end else if (a_rdy && a_res) begin
      cache_model[line_of(req_addr)] = req_addr;
      pending = 0;
      fill_ready = 1;
      fill_count++;
    end
    if (!a_rdy) begin
      chk("freeze_req", mc_fetch_enable_out, 0);
      chk("freeze_emit", iq_enable_out, 0);
    end
    if (mc_fetch_enable_out === 1'b1) begin
      chk("req_addr", mc_addr_out, exp_pc);
      chk("req_is_miss", model_hit(exp_pc), 0);
      chk("req_while_busy", {pending, a_res}, 0);
      pending = 1;
      req_addr = mc_addr_out;
      lat = rand_lat ? int'($urandom_range(1, 4)) : 2;
      req_count++;
    end else if (pending) begin
      chk("addr_hold", mc_addr_out, req_addr);
    end
    if (iq_enable_out === 1'b1) begin
      chk("emit_pc", iq_pc_out, exp_pc);
      chk("emit_instr", iq_instr_out, mem_word(exp_pc));
      chk("emit_not_full", a_full, 0);
      chk("emit_source", fill_ready || model_hit(exp_pc), 1);
      exp_pc = exp_pc + 32'd4;
      fill_ready = 0;
      emit_count++;
    end
    mc_result_enable_in = 0;
    mc_data_in = 32'h0;
    clear_flag_in = 0;
    if (pending) begin
      if (lat > 1) lat--;
      else begin
        mc_result_enable_in = 1;
        mc_data_in = mem_word(req_addr);
        rdy = 1;
      end
    end
  endtask

  task automatic wait_emit(int max_cycles, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (iq_enable_out === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h0; pending = 0; fill_ready = 0; cache_model.delete();
  endtask

  initial begin
    bit ok;
    int r0, f0, e0, idle;
    logic [31:0] tgt;
    rst = 0; rdy = 1; clear_flag_in = 0; clear_pc_in = 0;
    mc_result_enable_in = 0; mc_data_in = 0; iq_full_in = 0;
    rand_lat = 0; lat = 0; req_count = 0; emit_count = 0; fill_count = 0; req_addr = 0;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mc_addr", mc_addr_out, 32'hFFFF_FFFF);
    chk("rst_mc_fetch", mc_fetch_enable_out, 0);
    chk("rst_iq_en", iq_enable_out, 0);
    chk("rst_iq_instr", iq_instr_out, 0);
    chk("rst_iq_pc", iq_pc_out, 0);
    @(negedge clk) rst = 1;

    // first request at RESET_PC, one-cycle pulse
    tick();
    chk("t1_req", mc_fetch_enable_out, 1);
    chk("t1_addr", mc_addr_out, 32'h0);
    chk("t1_no_emit", iq_enable_out, 0);
    tick();
    chk("t1_pulse_len", mc_fetch_enable_out, 0);

    // fill delivers word with its pc, then next request at 0x4
    wait_emit(20, ok);
    chk("t2_emit_seen", ok, 1);
    chk("t2_instr", iq_instr_out, 32'h0050_0093);
    chk("t2_pc", iq_pc_out, 32'h0);
    tick();
    chk("t2_next_req", mc_fetch_enable_out, 1);
    chk("t2_next_addr", mc_addr_out, 32'h4);

    // fill 0x4..0xC, then replay 0x0..0xC
    for (int i = 1; i < 4; i++) begin
      wait_emit(20, ok);
      chk("t3_fill_emit", ok, 1);
    end
    clear_flag_in = 1; clear_pc_in = 32'h0;
    tick();
    r0 = req_count;
`ifdef ICACHE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_hit_emit", iq_enable_out, 1);
      chk("t3_hit_pc", iq_pc_out, 32'(i * 4));
    end
    chk("t3_no_req", req_count - r0, 0);
`else
    for (int i = 0; i < 4; i++) begin
      wait_emit(20, ok);
      chk("t3_emit", ok, 1);
    end
    chk("t3_reqs", req_count - r0, 4);
`endif

    // queue full when the result arrives
    clear_flag_in = 1; clear_pc_in = 32'h40; iq_full_in = 1;
    tick();
    f0 = fill_count;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_no_emit_full", iq_enable_out, 0);
      if (fill_count != f0) break;
    end
    chk("t4_fill_seen", fill_count - f0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_held", iq_enable_out, 0);
    end
    iq_full_in = 0;
    tick();
    chk("t4_emit", iq_enable_out, 1);
    chk("t4_pc", iq_pc_out, 32'h40);
    tick();
    chk("t4_single", iq_enable_out, 0);

    // clear coinciding with the result
    for (int i = 0; i < 10; i++) begin
      if (mc_result_enable_in) break;
      tick();
    end
    clear_flag_in = 1; clear_pc_in = 32'h100;
    tick();
    chk("t5_no_emit", iq_enable_out, 0);
    tick();
    chk("t5_req", mc_fetch_enable_out, 1);
    chk("t5_addr", mc_addr_out, 32'h100);
    wait_emit(20, ok);
    chk("t5_emit_100", iq_pc_out, 32'h100);
    clear_flag_in = 1; clear_pc_in = 32'h44;
    tick();
    tick();
    chk("t5_no_write", mc_fetch_enable_out, 1);
    chk("t5_no_write_addr", mc_addr_out, 32'h44);

    // reset while waiting, then conflict misses 0x0 / 0x100 / 0x0
    #2 rst = 0;
    #1;
    chk("t6_rst_addr", mc_addr_out, 32'hFFFF_FFFF);
    chk("t6_rst_req", mc_fetch_enable_out, 0);
    mc_result_enable_in = 1; mc_data_in = 32'hDEAD_BEEF; clear_flag_in = 0;
    repeat (2) @(posedge clk);
    mc_result_enable_in = 0; mc_data_in = 0;
    model_reset();
    @(negedge clk) rst = 1;
    r0 = req_count;
    tick();
    chk("t6_req0", mc_fetch_enable_out, 1);
    chk("t6_addr0", mc_addr_out, 32'h0);
    wait_emit(20, ok);
    chk("t6_emit0", iq_pc_out, 32'h0);
    clear_flag_in = 1; clear_pc_in = 32'h100;
    tick();
    wait_emit(20, ok);
    chk("t6_emit100", iq_pc_out, 32'h100);
    clear_flag_in = 1; clear_pc_in = 32'h0;
    tick();
    wait_emit(20, ok);
    chk("t6_emit0_again", iq_pc_out, 32'h0);
    chk("t6_misses", req_count - r0, 3);

    // randomized traffic: queue back-pressure, freezes, redirects, latency
    rand_lat = 1;
    e0 = emit_count;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      iq_full_in = ($urandom_range(0, 3) == 0);
      rdy = mc_result_enable_in ? 1'b1 : ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    tgt = 32'($urandom_range(0, 15)) * 4;
          2:       tgt = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          default: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
        endcase
        clear_flag_in = 1;
        clear_pc_in = tgt | 32'($urandom_range(0, 3));
      end
      tick();
      if (iq_enable_out === 1'b1) idle = 0;
      else idle++;
      if (idle > 150) break;
    end
    chk("rand_stall", idle > 150, 0);
    chk("rand_progress", (emit_count - e0) > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
